// File: rtl/seq_table_loader.sv
// Streams a sequencer table from a valid/ready word source into the sequencer
// table write port: clear pulse, paced data strobes, then a length commit.
module seq_table_loader #(
  parameter int MAX_WORDS = 4096,
  parameter int WSTB_GAP  = 0,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_start_i,
  input  logic [15:0] load_length_i,
  input  logic        abort_i,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic        TABLE_START_o,
  output logic [31:0] TABLE_DATA_o,
  output logic        TABLE_WSTB_o,
  output logic [15:0] TABLE_LENGTH_o,
  output logic        TABLE_LENGTH_WSTB_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  error_o,
  output logic [15:0] words_o
);

  localparam logic [16:0] MAX_LEN    = 17'(MAX_WORDS);
  localparam logic [3:0]  GAP_INIT   = 4'(WSTB_GAP);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic        TIMEOUT_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    LOAD   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] len_r;
  logic [15:0] words_r;
  logic [3:0]  gap_cnt_r;
  logic [15:0] stall_cnt_r;
  logic        start_r;
  logic [31:0] data_r;
  logic        wstb_r;
  logic [15:0] length_r;
  logic        length_wstb_r;
  logic        busy_r;
  logic        done_r;
  logic [1:0]  error_r;

  logic        ready_s;
  logic        handshake_s;
  logic        stall_hit_s;
  logic [15:0] words_next_s;

  // A table must be whole lines (4 words), non-empty and fit the sequencer.
  function automatic logic length_ok(input logic [15:0] len);
    return (len != 16'd0) && (len[1:0] == 2'b00) && ({1'b0, len} <= MAX_LEN);
  endfunction

  // Source is ready only in LOAD once the strobe gap has drained; abort vetoes the word.
  always_comb begin
    ready_s = 1'b0;
    if ((state_r == LOAD) && (gap_cnt_r == 4'd0) && !abort_i) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign handshake_s  = s_valid_i & ready_s;
  assign words_next_s = words_r + 16'd1;
  assign stall_hit_s  = TIMEOUT_EN & (stall_cnt_r == TIMEOUT_M1);

  // Load sequencer: one-cycle strobes default low and are raised only on the cycle they apply.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r       <= IDLE;
      len_r         <= 16'd0;
      words_r       <= 16'd0;
      gap_cnt_r     <= 4'd0;
      stall_cnt_r   <= 16'd0;
      start_r       <= 1'b0;
      data_r        <= 32'd0;
      wstb_r        <= 1'b0;
      length_r      <= 16'd0;
      length_wstb_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= ERR_NONE;
    end else begin
      start_r       <= 1'b0;
      wstb_r        <= 1'b0;
      length_wstb_r <= 1'b0;
      done_r        <= 1'b0;
      if (gap_cnt_r != 4'd0) begin
        gap_cnt_r <= gap_cnt_r - 4'd1;
      end
      case (state_r)
        IDLE: begin
          if (load_start_i) begin
            if (length_ok(load_length_i)) begin
              len_r       <= load_length_i;
              words_r     <= 16'd0;
              error_r     <= ERR_NONE;
              gap_cnt_r   <= 4'd0;
              stall_cnt_r <= 16'd0;
              start_r     <= 1'b1;
              busy_r      <= 1'b1;
              state_r     <= START;
            end else begin
              error_r <= ERR_LENGTH;
            end
          end
        end
        START: begin
          if (abort_i) begin
            error_r <= ERR_ABORT;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (abort_i) begin
            error_r <= ERR_ABORT;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (handshake_s) begin
            data_r      <= s_data_i;
            wstb_r      <= 1'b1;
            words_r     <= words_next_s;
            gap_cnt_r   <= GAP_INIT;
            stall_cnt_r <= 16'd0;
            // The commit strobe lands together with the final data strobe.
            if (words_next_s == len_r) begin
              length_r      <= words_next_s;
              length_wstb_r <= 1'b1;
              done_r        <= 1'b1;
              state_r       <= COMMIT;
            end
          end else if (stall_hit_s) begin
            error_r <= ERR_TIMEOUT;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
          end
        end
        COMMIT: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign s_ready_o           = ready_s;
  assign TABLE_START_o       = start_r;
  assign TABLE_DATA_o        = data_r;
  assign TABLE_WSTB_o        = wstb_r;
  assign TABLE_LENGTH_o      = length_r;
  assign TABLE_LENGTH_WSTB_o = length_wstb_r;
  assign busy_o              = busy_r;
  assign done_o              = done_r;
  assign error_o             = error_r;
  assign words_o             = words_r;

endmodule

// File: tb/tb_seq_table_loader.sv
// Directed bench for seq_table_loader: two instances (strobe gap 0 and 2, both
// with a short stall timeout) driven from one word source model.
`timescale 1ns/1ps
module tb_seq_table_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        load_start_a, load_start_b;
  logic [15:0] load_length;
  logic        abort;
  logic [31:0] s_data;
  logic        s_valid;

  logic        ready_a, start_a, wstb_a, lw_a, busy_a, done_a;
  logic [31:0] data_a;
  logic [15:0] tlen_a, words_a;
  logic [1:0]  error_a;
  logic        ready_b, start_b, wstb_b, lw_b, busy_b, done_b;
  logic [31:0] data_b;
  logic [15:0] tlen_b, words_b;
  logic [1:0]  error_b;

  seq_table_loader #(.MAX_WORDS(4096), .WSTB_GAP(0), .TIMEOUT(10)) dut_a (
    .clk_i(clk), .reset_i(reset_n), .load_start_i(load_start_a), .load_length_i(load_length),
    .abort_i(abort), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(ready_a),
    .TABLE_START_o(start_a), .TABLE_DATA_o(data_a), .TABLE_WSTB_o(wstb_a),
    .TABLE_LENGTH_o(tlen_a), .TABLE_LENGTH_WSTB_o(lw_a), .busy_o(busy_a),
    .done_o(done_a), .error_o(error_a), .words_o(words_a));

  seq_table_loader #(.MAX_WORDS(4096), .WSTB_GAP(2), .TIMEOUT(10)) dut_b (
    .clk_i(clk), .reset_i(reset_n), .load_start_i(load_start_b), .load_length_i(load_length),
    .abort_i(abort), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(ready_b),
    .TABLE_START_o(start_b), .TABLE_DATA_o(data_b), .TABLE_WSTB_o(wstb_b),
    .TABLE_LENGTH_o(tlen_b), .TABLE_LENGTH_WSTB_o(lw_b), .busy_o(busy_b),
    .done_o(done_b), .error_o(error_b), .words_o(words_b));

  int n_checks = 0;
  int n_fail   = 0;

  // source model state
  bit src_on = 1'b0, src_toggle = 1'b0, use_b = 1'b0, phase = 1'b0;
  int sent = 0, src_limit = 0;

  // monitor state
  int cyc = 0;
  bit hs_sel = 1'b0;
  int n_start_a, n_wstb_a, n_lw_a, n_done_a, n_wstb_b, n_lw_b, last_hs_a, err3_a;
  logic [31:0] wlog_a[$], wlog_b[$];
  int wcyc_a[$], wcyc_b[$];
  logic [15:0] len_at_lw_a, words_at_lw_b, len_at_lw_b;
  logic        wstb_at_lw_a;
  logic [31:0] data_at_lw_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe both instances away from the active edge.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    hs_sel <= s_valid && (use_b ? ready_b : ready_a);
    if (s_valid && ready_a) last_hs_a <= cyc;
    if (start_a) n_start_a <= n_start_a + 1;
    if (wstb_a) begin
      n_wstb_a <= n_wstb_a + 1;
      wlog_a.push_back(data_a);
      wcyc_a.push_back(cyc);
    end
    if (lw_a) begin
      n_lw_a       <= n_lw_a + 1;
      len_at_lw_a  <= tlen_a;
      wstb_at_lw_a <= wstb_a;
      data_at_lw_a <= data_a;
    end
    if (done_a) n_done_a <= n_done_a + 1;
    if ((error_a == 2'd3) && (err3_a < 0)) err3_a <= cyc;
    if (wstb_b) begin
      n_wstb_b <= n_wstb_b + 1;
      wlog_b.push_back(data_b);
      wcyc_b.push_back(cyc);
    end
    if (lw_b) begin
      n_lw_b        <= n_lw_b + 1;
      len_at_lw_b   <= tlen_b;
      words_at_lw_b <= words_b;
    end
  end

  task automatic clear_mon();
    n_start_a = 0; n_wstb_a = 0; n_lw_a = 0; n_done_a = 0;
    n_wstb_b = 0; n_lw_b = 0; last_hs_a = -1; err3_a = -1;
    wlog_a.delete(); wlog_b.delete(); wcyc_a.delete(); wcyc_b.delete();
  endtask

  // Advance one cycle; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
    if (src_on && hs_sel) begin
      sent   = sent + 1;
      s_data = s_data + 32'd1;
    end
    phase   = ~phase;
    s_valid = src_on && (sent < src_limit) && (!src_toggle || phase);
  endtask

  task automatic start_src(input int limit, input bit toggle);
    s_data = 32'd1; sent = 0; src_limit = limit; src_toggle = toggle;
    src_on = 1'b1; phase = 1'b0; s_valid = 1'b1;
  endtask

  initial begin
    int max_d, min_d;
    reset_n = 1'b0; load_start_a = 1'b0; load_start_b = 1'b0; load_length = 16'd0;
    abort = 1'b0; s_data = 32'd0; s_valid = 1'b0;
    clear_mon();
    tick(); tick();
    @(negedge clk);
    check_eq("reset busy", 32'(busy_a), 32'd0);
    check_eq("reset error", 32'(error_a), 32'd0);
    check_eq("reset data", data_a, 32'd0);
    check_eq("reset words", 32'(words_a), 32'd0);
    check_eq("reset ready", 32'(ready_a), 32'd0);
    reset_n = 1'b1;
    tick();

    // 8 words, gap 0, valid always high
    clear_mon();
    start_src(8, 1'b0);
    load_length = 16'd8; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    @(negedge clk);
    check_eq("g0 start pulse", 32'(start_a), 32'd1);
    check_eq("g0 busy", 32'(busy_a), 32'd1);
    check_eq("g0 ready in start", 32'(ready_a), 32'd0);
    for (int i = 0; i < 40 && n_lw_a == 0; i++) tick();
    src_on = 1'b0;
    check_eq("g0 commit count", 32'(n_lw_a), 32'd1);
    check_eq("g0 done count", 32'(n_done_a), 32'd1);
    check_eq("g0 start count", 32'(n_start_a), 32'd1);
    check_eq("g0 wstb count", 32'(n_wstb_a), 32'd8);
    check_eq("g0 length", 32'(len_at_lw_a), 32'd8);
    check_eq("g0 wstb with commit", 32'(wstb_at_lw_a), 32'd1);
    check_eq("g0 data with commit", data_at_lw_a, 32'd8);
    for (int i = 0; i < wlog_a.size() && i < 8; i++) check_eq("g0 data order", wlog_a[i], 32'(i + 1));
    max_d = 0;
    for (int i = 1; i < wcyc_a.size(); i++) if (wcyc_a[i] - wcyc_a[i-1] > max_d) max_d = wcyc_a[i] - wcyc_a[i-1];
    check_eq("g0 spacing", 32'(max_d), 32'd1);
    check_eq("g0 error", 32'(error_a), 32'd0);
    check_eq("g0 busy after", 32'(busy_a), 32'd0);

    // 8 words, gap 2, valid toggling
    clear_mon();
    use_b = 1'b1;
    start_src(8, 1'b1);
    load_length = 16'd8; load_start_b = 1'b1;
    tick();
    load_start_b = 1'b0;
    for (int i = 0; i < 120 && n_lw_b == 0; i++) tick();
    src_on = 1'b0; use_b = 1'b0;
    check_eq("g2 commit count", 32'(n_lw_b), 32'd1);
    check_eq("g2 wstb count", 32'(n_wstb_b), 32'd8);
    check_eq("g2 words at commit", 32'(words_at_lw_b), 32'd8);
    check_eq("g2 length", 32'(len_at_lw_b), 32'd8);
    for (int i = 0; i < wlog_b.size() && i < 8; i++) check_eq("g2 data order", wlog_b[i], 32'(i + 1));
    min_d = 1000;
    for (int i = 1; i < wcyc_b.size(); i++) if (wcyc_b[i] - wcyc_b[i-1] < min_d) min_d = wcyc_b[i] - wcyc_b[i-1];
    check_eq("g2 spacing>=3", 32'(min_d >= 3), 32'd1);
    check_eq("g2 error", 32'(error_b), 32'd0);

    // invalid lengths
    clear_mon();
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_length = (k == 0) ? 16'd6 : ((k == 1) ? 16'd0 : 16'd4100);
      load_start_a = 1'b1;
      tick();
      load_start_a = 1'b0;
      @(negedge clk);
      check_eq("badlen error", 32'(error_a), 32'd1);
      check_eq("badlen busy", 32'(busy_a), 32'd0);
      tick();
      @(negedge clk);
      check_eq("badlen busy later", 32'(busy_a), 32'd0);
    end
    check_eq("badlen no start", 32'(n_start_a), 32'd0);

    // length 12, abort with the 6th valid word
    tick();
    clear_mon();
    start_src(12, 1'b0);
    load_length = 16'd12; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    for (int i = 0; i < 40 && sent < 5; i++) tick();
    abort = 1'b1;
    @(negedge clk);
    check_eq("abort blocks ready", 32'(ready_a), 32'd0);
    check_eq("abort prior wstb", 32'(wstb_a), 32'd1);
    src_on = 1'b0;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort error", 32'(error_a), 32'd2);
    check_eq("abort busy", 32'(busy_a), 32'd0);
    tick(); tick();
    check_eq("abort wstb count", 32'(n_wstb_a), 32'd5);
    check_eq("abort no commit", 32'(n_lw_a), 32'd0);
    check_eq("abort no done", 32'(n_done_a), 32'd0);

    // next valid load clears the error
    clear_mon();
    start_src(4, 1'b0);
    load_length = 16'd4; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    @(negedge clk);
    check_eq("reload error clear", 32'(error_a), 32'd0);
    check_eq("reload start", 32'(start_a), 32'd1);
    for (int i = 0; i < 30 && n_lw_a == 0; i++) tick();
    src_on = 1'b0;
    check_eq("reload commit", 32'(n_lw_a), 32'd1);
    check_eq("reload length", 32'(len_at_lw_a), 32'd4);

    // timeout after two words
    tick();
    clear_mon();
    start_src(2, 1'b0);
    load_length = 16'd4; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    for (int i = 0; i < 40 && err3_a < 0; i++) tick();
    src_on = 1'b0;
    check_eq("timeout latency", 32'(err3_a - last_hs_a), 32'd11);
    check_eq("timeout wstb count", 32'(n_wstb_a), 32'd2);
    check_eq("timeout no commit", 32'(n_lw_a), 32'd0);
    check_eq("timeout busy", 32'(busy_a), 32'd0);
    check_eq("timeout error", 32'(error_a), 32'd3);

    // reset during LOAD
    tick();
    clear_mon();
    start_src(12, 1'b0);
    load_length = 16'd12; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    for (int i = 0; i < 40 && sent < 3; i++) tick();
    reset_n = 1'b0;
    src_on = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst busy", 32'(busy_a), 32'd0);
    check_eq("midrst data", data_a, 32'd0);
    check_eq("midrst words", 32'(words_a), 32'd0);
    check_eq("midrst length", 32'(tlen_a), 32'd0);
    check_eq("midrst error", 32'(error_a), 32'd0);
    check_eq("midrst strobes", 32'({start_a, wstb_a, lw_a, done_a, ready_a}), 32'd0);
    tick();
    check_eq("midrst no commit", 32'(n_lw_a), 32'd0);
    clear_mon();
    start_src(4, 1'b0);
    load_length = 16'd4; load_start_a = 1'b1;
    tick();
    load_start_a = 1'b0;
    for (int i = 0; i < 30 && n_lw_a == 0; i++) tick();
    src_on = 1'b0;
    check_eq("postrst commit", 32'(n_lw_a), 32'd1);
    check_eq("postrst length", 32'(len_at_lw_a), 32'd4);
    check_eq("postrst wstb count", 32'(n_wstb_a), 32'd4);
    check_eq("postrst error", 32'(error_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_table_loader.md
# seq_table_loader

Streams a sequencer table from a 32-bit valid/ready word source (DMA FIFO) into the sequencer's table write port. It drives TABLE_START, TABLE_DATA/TABLE_WSTB and TABLE_LENGTH/TABLE_LENGTH_WSTB in the order and spacing the sequencer expects. It validates the requested length, paces writes, and reports completion or failure. It sits between the table DMA engine and the sequencer block: the sequencer is the reader of the table, and this block is its writer.

## Interface
- MAX_WORDS, 4096: maximum table size in 32-bit words (1024 lines × 4 words).
- WSTB_GAP, 0: idle cycles forced between consecutive TABLE_WSTB_o pulses (0..15).
- TIMEOUT, 65535: cycles in LOAD with no accepted word before stall error; 0 disables.
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- load_start_i  in  1  single-cycle request to load a table.
- load_length_i  in  16  table length in words; sampled with load_start_i.
- abort_i  in  1  cancel load in progress.
- s_data_i  in  32  source word.
- s_valid_i  in  1  source word valid.
- s_ready_o  out  1  block accepts word this cycle.
- TABLE_START_o  out  1  one-cycle pulse to sequencer: clear table.
- TABLE_DATA_o  out  32  table word to sequencer.
- TABLE_WSTB_o  out  1  one-cycle write strobe qualifying TABLE_DATA_o.
- TABLE_LENGTH_o  out  16  number of words written.
- TABLE_LENGTH_WSTB_o  out  1  one-cycle commit strobe.
- busy_o  out  1  high in START, LOAD, COMMIT.
- done_o  out  1  one-cycle pulse on successful commit.
- error_o  out  2  0 none, 1 bad length, 2 aborted, 3 timeout; sticky until next accepted load_start_i.
- words_o  out  16  words accepted so far in current/last load.

## Operation
- States: IDLE, START, LOAD, COMMIT.
- IDLE: on load_start_i, the length is valid if it is nonzero, a multiple of 4, and ≤ MAX_WORDS.
  - Valid: latch length, clear error_o and words_o, go to START.
  - Invalid: error_o=1, stay in IDLE, no strobes issued.
- START: TABLE_START_o=1 for exactly this cycle; go to LOAD.
- LOAD:
  - s_ready_o = (gap_cnt==0) & ~abort_i.
  - Handshake is s_valid_i & s_ready_o: register word to TABLE_DATA_o, pulse TABLE_WSTB_o next cycle, increment words_o, load gap_cnt=WSTB_GAP.
  - gap_cnt decrements to 0 each cycle.
  - When words_o reaches the latched length (after the last handshake), go to COMMIT.
- COMMIT: TABLE_LENGTH_o=words_o, TABLE_LENGTH_WSTB_o=1 and done_o=1 for this cycle; go to IDLE.
- abort_i in START or LOAD: go to IDLE, error_o=2, no TABLE_LENGTH_WSTB_o. The sequencer keeps a cleared/partial table that is never committed.
- Timeout: stall counter resets on each handshake. Reaching TIMEOUT in LOAD → IDLE, error_o=3.
- load_start_i while busy_o=1: ignored, no state change.
- abort_i in IDLE or COMMIT: ignored. COMMIT always completes.
- Extra source words after the length is reached: not accepted (s_ready_o=0 outside LOAD).
- TABLE_DATA_o holds its last value between strobes.

## Timing
- Reset (reset_i=0 at clock edge): state IDLE; all outputs 0, including TABLE_DATA_o, TABLE_LENGTH_o, words_o and error_o. Reset mid-load drops the load immediately with no commit strobe.
- load_start_i at cycle T (valid) → TABLE_START_o at T+1 → s_ready_o may be high from T+2.
- Handshake at cycle H → TABLE_WSTB_o and TABLE_DATA_o valid at H+1; next s_ready_o no earlier than H+1+WSTB_GAP.
- WSTB_GAP=0: one word per cycle sustained.
- Last handshake at cycle N → TABLE_WSTB_o at N+1 (state COMMIT) → TABLE_LENGTH_WSTB_o and done_o at N+1. The commit strobe coincides with the final data strobe; the sequencer registers TABLE_WSTB before evaluating TABLE_LENGTH_WSTB.
- abort_i asserted in the same cycle as s_valid_i: abort wins and the word is not accepted. The WSTB for a word accepted in the previous cycle still issues.
- busy_o falls the cycle after COMMIT or the abort/timeout cycle.

## Test plan
- Load 8 words 0x1..0x8, WSTB_GAP=0, s_valid_i always high.
  - TABLE_START_o pulse, then 8 consecutive TABLE_WSTB_o with data 1..8.
  - TABLE_LENGTH_o=8, TABLE_LENGTH_WSTB_o and done_o together with the 8th WSTB; error_o=0.
- Same load, WSTB_GAP=2, s_valid_i toggling every other cycle.
  - WSTB pulses spaced ≥3 cycles, data in order, words_o=8 at commit.
- load_length_i values 6, 0, and 4100 (MAX_WORDS=4096).
  - Each gives error_o=1, no TABLE_START_o, busy_o stays 0.
- Length 12, abort_i after 5 handshakes, asserted together with a 6th valid word.
  - Exactly 5 WSTB pulses, no TABLE_LENGTH_WSTB_o, error_o=2.
  - A following valid load clears error_o to 0.
- TIMEOUT=10, length 4, s_valid_i high for 2 words then low.
  - 10 cycles after the 2nd handshake: error_o=3, IDLE, no commit.
- reset_i=0 for one cycle during LOAD.
  - All outputs 0 next cycle; load_start_i with length 4 afterwards completes normally.
